// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirects, a one-entry stall skid
// buffer, the ID pipeline register and a saturating bubble counter.

// Property checker kept apart from the datapath.
module fetch_stage_checker (
    input logic clk,
    input logic reset_n,
    input logic pc_reset,
    input logic int_take,
    input logic pc_load,
    input logic dec_nop,
    input logic id_valid
);

    // Any redirect or bubble request must leave the ID register empty.
    a_kill_id: assert property (@(posedge clk) disable iff (!reset_n)
        (pc_reset || int_take || pc_load || dec_nop) |=> !id_valid);

endmodule

module fetch_stage #(
    parameter int                 PC_W       = 10,
    parameter int                 INSTR_W    = 18,
    parameter logic [PC_W-1:0]    INT_VECTOR = 10'h3FF,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = 18'h00000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pc_reset,
    input  logic               int_take,
    input  logic               pc_load,
    input  logic [PC_W-1:0]    branch_addr,
    input  logic               stall,
    input  logic               dec_nop,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic               id_valid,
    output logic [PC_W-1:0]    ret_pc,
    output logic [15:0]        bubble_count
);

    localparam logic [PC_W-1:0] PC_ZERO = {PC_W{1'b0}};
    localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]     BUB_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        ACT_CLEAR = 3'd0,
        ACT_INT   = 3'd1,
        ACT_LOAD  = 3'd2,
        ACT_HOLD  = 3'd3,
        ACT_ADV   = 3'd4
    } action_e;

    action_e            action_s;
    logic [PC_W-1:0]    pc_r, pc_s;
    logic [PC_W-1:0]    f_pc_r, f_pc_s;
    logic               f_valid_r, f_valid_s;
    logic [INSTR_W-1:0] hold_instr_r, hold_instr_s;
    logic               hold_valid_r, hold_valid_s;
    logic [INSTR_W-1:0] id_instr_r, id_instr_s;
    logic [PC_W-1:0]    id_pc_r, id_pc_s;
    logic               id_valid_r, id_valid_s;
    logic [PC_W-1:0]    ret_pc_r, ret_pc_s;
    logic [15:0]        bubble_count_r, bubble_count_s;
    logic [INSTR_W-1:0] fetched_instr_s;

    // The skid buffer, once filled by a stall, takes over from the memory port.
    assign fetched_instr_s = hold_valid_r ? hold_instr_r : imem_data;

    // Resolve the per-edge priority between redirects, stall and advance.
    always_comb begin
        if (pc_reset) begin
            action_s = ACT_CLEAR;
        end else if (int_take) begin
            action_s = ACT_INT;
        end else if (pc_load) begin
            action_s = ACT_LOAD;
        end else if (stall) begin
            action_s = ACT_HOLD;
        end else begin
            action_s = ACT_ADV;
        end
    end

    // Next-state computation for all fetch and ID state.
    always_comb begin
        pc_s           = pc_r;
        f_pc_s         = f_pc_r;
        f_valid_s      = f_valid_r;
        hold_instr_s   = hold_instr_r;
        hold_valid_s   = hold_valid_r;
        id_instr_s     = id_instr_r;
        id_pc_s        = id_pc_r;
        id_valid_s     = id_valid_r;
        ret_pc_s       = ret_pc_r;

        if (!id_valid_r && (bubble_count_r != BUB_MAX)) begin
            bubble_count_s = bubble_count_r + 16'd1;
        end else begin
            bubble_count_s = bubble_count_r;
        end

        case (action_s)
            ACT_CLEAR: begin
                pc_s           = PC_ZERO;
                f_valid_s      = 1'b0;
                hold_valid_s   = 1'b0;
                id_valid_s     = 1'b0;
                id_instr_s     = NOP_INSTR;
                bubble_count_s = 16'h0000;
            end
            ACT_INT: begin
                // Return to the oldest instruction not yet handed to decode.
                ret_pc_s     = f_valid_r ? f_pc_r : pc_r;
                pc_s         = INT_VECTOR;
                f_valid_s    = 1'b0;
                hold_valid_s = 1'b0;
                id_valid_s   = 1'b0;
                id_instr_s   = NOP_INSTR;
            end
            ACT_LOAD: begin
                pc_s         = branch_addr;
                f_valid_s    = 1'b0;
                hold_valid_s = 1'b0;
                id_valid_s   = 1'b0;
                id_instr_s   = NOP_INSTR;
            end
            ACT_HOLD: begin
                // Memory will return mem[pc] next cycle, so keep the in-flight word.
                if (!hold_valid_r && f_valid_r) begin
                    hold_instr_s = imem_data;
                    hold_valid_s = 1'b1;
                end else begin
                    hold_instr_s = hold_instr_r;
                    hold_valid_s = hold_valid_r;
                end
                if (dec_nop) begin
                    id_valid_s = 1'b0;
                    id_instr_s = NOP_INSTR;
                end else begin
                    id_valid_s = id_valid_r;
                    id_instr_s = id_instr_r;
                end
            end
            ACT_ADV: begin
                if (dec_nop) begin
                    id_valid_s = 1'b0;
                    id_instr_s = NOP_INSTR;
                end else begin
                    id_valid_s = f_valid_r;
                    id_instr_s = fetched_instr_s;
                    // id_pc only moves with a real instruction.
                    if (f_valid_r) begin
                        id_pc_s = f_pc_r;
                    end else begin
                        id_pc_s = id_pc_r;
                    end
                end
                f_pc_s       = pc_r;
                f_valid_s    = 1'b1;
                pc_s         = pc_r + PC_ONE;
                hold_valid_s = 1'b0;
            end
            default: begin
                pc_s      = pc_r;
                f_valid_s = f_valid_r;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r           <= PC_ZERO;
            f_pc_r         <= PC_ZERO;
            f_valid_r      <= 1'b0;
            hold_instr_r   <= NOP_INSTR;
            hold_valid_r   <= 1'b0;
            id_instr_r     <= NOP_INSTR;
            id_pc_r        <= PC_ZERO;
            id_valid_r     <= 1'b0;
            ret_pc_r       <= PC_ZERO;
            bubble_count_r <= 16'h0000;
        end else begin
            pc_r           <= pc_s;
            f_pc_r         <= f_pc_s;
            f_valid_r      <= f_valid_s;
            hold_instr_r   <= hold_instr_s;
            hold_valid_r   <= hold_valid_s;
            id_instr_r     <= id_instr_s;
            id_pc_r        <= id_pc_s;
            id_valid_r     <= id_valid_s;
            ret_pc_r       <= ret_pc_s;
            bubble_count_r <= bubble_count_s;
        end
    end

    assign imem_addr    = pc_r;
    assign id_instr     = id_instr_r;
    assign id_pc        = id_pc_r;
    assign id_valid     = id_valid_r;
    assign ret_pc       = ret_pc_r;
    assign bubble_count = bubble_count_r;

    fetch_stage_checker u_checker (
        .clk      (clk),
        .reset_n  (reset_n),
        .pc_reset (pc_reset),
        .int_take (int_take),
        .pc_load  (pc_load),
        .dec_nop  (dec_nop),
        .id_valid (id_valid)
    );

endmodule
